// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN  = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {StFetch, StHalt} fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = i_pop & (r_count != 2'd0);
  assign w_do_push = i_push & ((r_count != 2'd2) | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, ROM addressing, 2-entry return buffer and redirect flush.
// Optional FETCH_MISALIGN_EN: misaligned redirect halts fetch and presents a flagged NOP.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter int unsigned     MEMSIZE  = 32768,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic [$clog2(MEMSIZE)-1:0] rom_address,
  input  logic [XLEN-1:0]            rom_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [XLEN-1:0]            if_pc,
  output logic [XLEN-1:0]            if_instr
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                       if_misalign
`endif
);

  localparam int unsigned AW = $clog2(MEMSIZE);

  logic [XLEN-1:0] r_pc_next;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [1:0]      w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_ret;
  logic            w_halt;
  logic            w_fifo_valid;
  logic            w_fifo_pop;
  logic            w_push;
  logic            w_issue;
  logic [2:0]      w_occ;
  logic [XLEN-1:0] w_redirect_aligned;

  assign w_fifo_valid       = (w_count != 2'd0);
  assign w_fifo_pop         = w_fifo_valid & if_ready;
  // Occupancy the buffer would reach if this cycle's issue also returns.
  assign w_occ              = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_fifo_pop};
  assign w_issue            = !redirect_valid & !w_halt & (w_occ < 3'd2);
  assign w_push             = r_inflight & !redirect_valid;
  assign w_redirect_aligned = redirect_pc & ~XLEN'(3);
  assign w_ret              = '{pc: r_inflight_pc, instr: rom_data};
  assign rom_address        = r_pc_next[AW+1:2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc_next     <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc_next  <= w_redirect_aligned;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc_next;
      r_pc_next     <= r_pc_next + XLEN'(INSTR_BYTES);
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_ret),
    .i_pop   (w_fifo_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_head  (w_head)
  );

`ifdef FETCH_MISALIGN_EN
  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_halt_pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StFetch;
      r_halt_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) r_halt_pc <= redirect_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_halt      = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = (redirect_pc[1:0] != 2'b00) ? StHalt : StFetch;
    end
    unique case (r_state)
      StFetch: w_halt = 1'b0;
      StHalt:  w_halt = 1'b1;
      default: w_halt = 1'b0;
    endcase
  end

  assign if_valid    = w_halt | w_fifo_valid;
  assign if_pc       = w_halt ? r_halt_pc : w_head.pc;
  assign if_instr    = w_halt ? NOP_INSTR : w_head.instr;
  assign if_misalign = w_halt;
`else
  assign w_halt   = 1'b0;
  assign if_valid = w_fifo_valid;
  assign if_pc    = w_head.pc;
  assign if_instr = w_head.instr;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: driver queues the expected {pc, instr} stream, monitor checks pops.
module tb_inst_fetch;
  import fetch_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [14:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_EN
  logic        if_misalign;
`endif

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  bit mon_en = 1'b1;
  fetch_entry_t exp_q[$];

  inst_fetch dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_EN
    ,
    .if_misalign    (if_misalign)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM model: word i holds 0x1000_0000 + i, one-cycle read latency.
  initial rom_data = 32'h0;
  always @(posedge clock) rom_data <= 32'h1000_0000 + 32'(rom_address);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && mon_en && if_valid && if_ready) begin
      fetch_entry_t e;
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", if_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_instr", if_instr, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rebuild(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    p = start & ~32'h3;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{pc: p, instr: 32'h1000_0000 + ((p >> 2) & 32'h7FFF)});
      p = p + 32'd4;
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    rebuild(target);
    mon_en = 1'b1;
  endtask

  // Called in cycle n+1 of a redirect; checks timing, first output and full throughput.
  task automatic expect_restart(input logic [31:0] target);
    logic [31:0] a;
    a = target & ~32'h3;
    if_ready = 1'b1;
    pops = 0;
    check("rd_valid_n1", {31'b0, if_valid}, 32'd0);
    tick();
    check("rd_valid_n2", {31'b0, if_valid}, 32'd0);
    tick();
    check("rd_valid_n3", {31'b0, if_valid}, 32'd1);
    check("rd_pc_n3", if_pc, a);
    check("rd_instr_n3", if_instr, 32'h1000_0000 + ((a >> 2) & 32'h7FFF));
    repeat (8) tick();
    check("rd_throughput", pops, 8);
  endtask

  // Reset is low on entry; releases it and checks the first fetched words.
  task automatic release_reset();
    rebuild(32'h0);
    if_ready = 1'b1;
    pops = 0;
    reset_n = 1'b1;
    check("rst_rom_addr", 32'(rom_address), 32'd0);
    tick();
    check("rst_valid_c1", {31'b0, if_valid}, 32'd0);
    tick();
    check("rst_valid_c2", {31'b0, if_valid}, 32'd1);
    check("rst_pc_c2", if_pc, 32'h0);
    check("rst_instr_c2", if_instr, 32'h1000_0000);
    repeat (9) tick();
    check("rst_throughput", pops, 9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) tick();
    check("reset_valid", {31'b0, if_valid}, 32'd0);
    check("reset_pc", if_pc, 32'h0);
    check("reset_instr", if_instr, 32'h0);
    check("reset_rom_addr", 32'(rom_address), 32'd0);
    release_reset();

    // Back-pressure: buffer fills, fetch stops on pc_next = head + 8.
    if_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_pc", if_pc, exp_q[0].pc);
      check("stall_rom_addr", 32'(rom_address), ((exp_q[0].pc + 32'd8) >> 2) & 32'h7FFF);
      tick();
    end
    if_ready = 1'b1;
    repeat (6) tick();

    // Redirect with a full buffer and no pop.
    if_ready = 1'b0;
    tick();
    redirect(32'h40);
    expect_restart(32'h40);

    // Redirect coinciding with a pop and an inflight return.
    redirect(32'h300);
    expect_restart(32'h300);

    // Back-to-back redirects: last wins.
    redirect(32'h100);
    redirect(32'h200);
    expect_restart(32'h200);

    // ROM address truncation and PC wrap.
    redirect(32'h0002_0000);
    expect_restart(32'h0002_0000);
    redirect(32'hFFFF_FFF8);
    expect_restart(32'hFFFF_FFF8);

`ifdef FETCH_MISALIGN_EN
    mon_en         = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("halt_valid", {31'b0, if_valid}, 32'd1);
      check("halt_pc", if_pc, 32'h42);
      check("halt_instr", if_instr, 32'h13);
      check("halt_flag", {31'b0, if_misalign}, 32'd1);
      tick();
    end
    redirect(32'h80);
    expect_restart(32'h80);
    check("halt_exit_flag", {31'b0, if_misalign}, 32'd0);
`else
    // Low address bits of a redirect are dropped.
    redirect(32'h46);
    expect_restart(32'h44);
`endif

    // Asynchronous reset in the middle of streaming.
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset_valid", {31'b0, if_valid}, 32'd0);
    check("areset_pc", if_pc, 32'h0);
    check("areset_instr", if_instr, 32'h0);
    check("areset_rom_addr", 32'(rom_address), 32'd0);
    tick();
    release_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
